risc_vt_mem: RTL and testbench

Wait-state memory model/controller that sits directly on the core's program or data memory port, one instance per port. Serves the core's `wr`/`rd` commands through the `wr_en`/`rd_en` acceptance handshake and returns read data with a one-cycle `dout_rdy` strobe. Adds a programmable number of wait states, so the core's stall logic is exercised the same way on both ports.

---
 rtl/risc_vt_mem.sv | 138 +++++++++++++
 tb/tb_risc_vt_mem.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/risc_vt_mem.sv
// risc_vt_mem: single-port word memory with a programmable number of wait
// states per access. It accepts one write or read command at a time through
// the wr_en/rd_en handshake and returns read data with a one-cycle dout_rdy
// strobe.
module risc_vt_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  dout_rdy,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic                    rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    mem_we;
  logic                    rd_load;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Next-state logic: accept one command in IDLE, count down the wait
  // states, then perform the access. A simultaneous read is dropped in
  // favour of the write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rdy_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    mem_we  = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr && en_q) begin
          state_d = WR_WAIT;
          en_d    = 1'b0;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = addr;
          din_d   = din;
        end else if (rd && en_q) begin
          state_d = RD_WAIT;
          en_d    = 1'b0;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = addr;
        end
      end
      WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = 1'b1;
          state_d = IDLE;
          en_d    = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rd_load = 1'b1;
          rdy_d   = 1'b1;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
        en_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b1;
      end
    endcase
  end

  // Control state and registered outputs; reset aborts any access in flight
  // and clears the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      en_q    <= 1'b1;
      rdy_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      if (rd_load) begin
        dout_q <= mem[addr_q];
      end
    end
  end

  // Command address/data latched at acceptance; later bus changes are ignored.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  // Array write at the end of the write wait; not performed under reset so a
  // reset during the wait leaves the array untouched.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[addr_q] <= din_q;
    end
  end

  assign wr_en    = en_q;
  assign rd_en    = en_q;
  assign dout_rdy = rdy_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_risc_vt_mem.sv
// Testbench for risc_vt_mem: a cycle-by-cycle vector table on a
// WAIT_CYCLES=2 instance, and hand-written back-to-back sequences on a
// WAIT_CYCLES=0 instance.
module tb_risc_vt_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 2 instance
  logic        rst2, wr2, rd2;
  logic        wr_en2, rd_en2, rdy2;
  logic [9:0]  addr2;
  logic [31:0] din2, dout2;

  // WAIT_CYCLES = 0 instance
  logic        rst0, wr0, rd0;
  logic        wr_en0, rd_en0, rdy0;
  logic [9:0]  addr0;
  logic [31:0] din0, dout0;

  risc_vt_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .wr(wr2), .rd(rd2),
    .wr_en(wr_en2), .rd_en(rd_en2), .dout_rdy(rdy2),
    .addr(addr2), .din(din2), .dout(dout2)
  );

  risc_vt_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .wr(wr0), .rd(rd0),
    .wr_en(wr_en0), .rd_en(rd_en0), .dout_rdy(rdy0),
    .addr(addr0), .din(din0), .dout(dout0)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [9:0]  addr;
    logic [31:0] din;
    logic        en;
    logic        rdy;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic r, input logic w, input logic d,
                              input logic [9:0] a, input logic [31:0] di,
                              input logic en, input logic rdy,
                              input logic [31:0] dout);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = d; v.addr = a; v.din = di;
    v.en = en; v.rdy = rdy; v.dout = dout;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk0(input string nm, input logic en, input logic rdy, input logic [31:0] dout);
    chk({nm, ".wr_en"}, {31'd0, wr_en0}, {31'd0, en});
    chk({nm, ".rd_en"}, {31'd0, rd_en0}, {31'd0, en});
    chk({nm, ".dout_rdy"}, {31'd0, rdy0}, {31'd0, rdy});
    chk({nm, ".dout"}, dout0, dout);
  endtask

  initial begin
    rst2 = 1'b1; wr2 = 1'b0; rd2 = 1'b0; addr2 = '0; din2 = '0;
    rst0 = 1'b1; wr0 = 1'b0; rd0 = 1'b0; addr0 = '0; din0 = '0;

    // rst wr rd addr din | en rdy dout   (checked after each rising edge)
    // reset with both commands asserted
    add(1,1,1,10'h020,32'h0,1,0,32'h0);
    add(1,1,1,10'h020,32'h0,1,0,32'h0);
    // write 0x005 = DEADBEEF, three busy cycles
    add(0,1,0,10'h005,32'hDEADBEEF,0,0,32'h0);
    add(0,0,0,10'h005,32'hDEADBEEF,0,0,32'h0);
    add(0,0,0,10'h005,32'hDEADBEEF,0,0,32'h0);
    add(0,0,0,10'h005,32'hDEADBEEF,1,0,32'h0);
    // read 0x005 back
    add(0,0,1,10'h005,32'h0,0,0,32'h0);
    add(0,0,0,10'h005,32'h0,0,0,32'h0);
    add(0,0,0,10'h005,32'h0,0,0,32'h0);
    add(0,0,0,10'h005,32'h0,0,1,32'hDEADBEEF);
    add(0,0,0,10'h005,32'h0,1,0,32'hDEADBEEF);
    // simultaneous wr+rd: only the write happens, no strobe, dout unchanged
    add(0,1,1,10'h3FF,32'h12345678,0,0,32'hDEADBEEF);
    add(0,0,0,10'h3FF,32'h0,0,0,32'hDEADBEEF);
    add(0,0,0,10'h3FF,32'h0,0,0,32'hDEADBEEF);
    add(0,0,0,10'h3FF,32'h0,1,0,32'hDEADBEEF);
    add(0,0,1,10'h3FF,32'h0,0,0,32'hDEADBEEF);
    add(0,0,0,10'h3FF,32'h0,0,0,32'hDEADBEEF);
    add(0,0,0,10'h3FF,32'h0,0,0,32'hDEADBEEF);
    add(0,0,0,10'h3FF,32'h0,0,1,32'h12345678);
    add(0,0,0,10'h3FF,32'h0,1,0,32'h12345678);
    // commands and bus changes during WR_WAIT are ignored
    add(0,1,0,10'h100,32'hCAFEF00D,0,0,32'h12345678);
    add(0,1,1,10'h101,32'h0BADBAD0,0,0,32'h12345678);
    add(0,1,1,10'h101,32'h0BADBAD0,0,0,32'h12345678);
    add(0,1,1,10'h101,32'h0BADBAD0,1,0,32'h12345678);
    add(0,0,0,10'h101,32'h0,1,0,32'h12345678);
    add(0,0,1,10'h100,32'h0,0,0,32'h12345678);
    add(0,0,0,10'h100,32'h0,0,0,32'h12345678);
    add(0,0,0,10'h100,32'h0,0,0,32'h12345678);
    add(0,0,0,10'h100,32'h0,0,1,32'hCAFEF00D);
    add(0,0,0,10'h100,32'h0,1,0,32'hCAFEF00D);
    // prior contents 0x010 = 11111111, then a write aborted by reset
    add(0,1,0,10'h010,32'h11111111,0,0,32'hCAFEF00D);
    add(0,0,0,10'h010,32'h0,0,0,32'hCAFEF00D);
    add(0,0,0,10'h010,32'h0,0,0,32'hCAFEF00D);
    add(0,0,0,10'h010,32'h0,1,0,32'hCAFEF00D);
    add(0,1,0,10'h010,32'hAAAA5555,0,0,32'hCAFEF00D);
    add(1,0,0,10'h010,32'hAAAA5555,1,0,32'h0);
    add(0,0,1,10'h010,32'h0,0,0,32'h0);
    add(0,0,0,10'h010,32'h0,0,0,32'h0);
    add(0,0,0,10'h010,32'h0,0,0,32'h0);
    add(0,0,0,10'h010,32'h0,0,1,32'h11111111);
    add(0,0,0,10'h010,32'h0,1,0,32'h11111111);
    // reset during RD_DONE clears strobe and dout
    add(0,0,1,10'h010,32'h0,0,0,32'h11111111);
    add(0,0,0,10'h010,32'h0,0,0,32'h11111111);
    add(0,0,0,10'h010,32'h0,0,0,32'h11111111);
    add(0,0,0,10'h010,32'h0,0,1,32'h11111111);
    add(1,0,0,10'h010,32'h0,1,0,32'h0);
    // reset during RD_WAIT: no strobe follows
    add(0,0,1,10'h005,32'h0,0,0,32'h0);
    add(1,0,0,10'h005,32'h0,1,0,32'h0);
    add(0,0,0,10'h005,32'h0,1,0,32'h0);
    // write 0x020 = 600D, then reset with wr asserted must not write
    add(0,1,0,10'h020,32'h0000600D,0,0,32'h0);
    add(0,0,0,10'h020,32'h0,0,0,32'h0);
    add(0,0,0,10'h020,32'h0,0,0,32'h0);
    add(0,0,0,10'h020,32'h0,1,0,32'h0);
    add(1,1,1,10'h020,32'h00000BAD,1,0,32'h0);
    add(1,1,1,10'h020,32'h00000BAD,1,0,32'h0);
    add(0,0,1,10'h020,32'h0,0,0,32'h0);
    add(0,0,0,10'h020,32'h0,0,0,32'h0);
    add(0,0,0,10'h020,32'h0,0,0,32'h0);
    add(0,0,0,10'h020,32'h0,0,1,32'h0000600D);
    add(0,0,0,10'h020,32'h0,1,0,32'h0000600D);

    for (int i = 0; i < tbl.size(); i++) begin
      rst2 = tbl[i].rst; wr2 = tbl[i].wr; rd2 = tbl[i].rd;
      addr2 = tbl[i].addr; din2 = tbl[i].din;
      @(posedge clk); #1;
      chk($sformatf("v%0d.wr_en", i), {31'd0, wr_en2}, {31'd0, tbl[i].en});
      chk($sformatf("v%0d.rd_en", i), {31'd0, rd_en2}, {31'd0, tbl[i].en});
      chk($sformatf("v%0d.dout_rdy", i), {31'd0, rdy2}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d.dout", i), dout2, tbl[i].dout);
    end
    wr2 = 1'b0; rd2 = 1'b0;

    // WAIT_CYCLES=0: reset
    rst0 = 1'b1;
    @(posedge clk); #1; chk0("w0.reset", 1, 0, 32'h0);
    // write 0x001 accepted, busy for one cycle
    rst0 = 1'b0; wr0 = 1'b1; addr0 = 10'h001; din0 = 32'h00000001;
    @(posedge clk); #1; chk0("w0.wr1_acc", 0, 0, 32'h0);
    // second write held: ignored while busy, accepted on the next edge
    addr0 = 10'h002; din0 = 32'h00000002;
    @(posedge clk); #1; chk0("w0.wr1_done", 1, 0, 32'h0);
    @(posedge clk); #1; chk0("w0.wr2_acc", 0, 0, 32'h0);
    wr0 = 1'b0;
    @(posedge clk); #1; chk0("w0.wr2_done", 1, 0, 32'h0);
    // read 0x001: strobe at acceptance edge + 1
    rd0 = 1'b1; addr0 = 10'h001;
    @(posedge clk); #1; chk0("w0.rd1_acc", 0, 0, 32'h0);
    addr0 = 10'h002;
    @(posedge clk); #1; chk0("w0.rd1_rdy", 0, 1, 32'h00000001);
    // rd still held: ignored in RD_DONE, accepted once back in IDLE
    @(posedge clk); #1; chk0("w0.rd1_idle", 1, 0, 32'h00000001);
    @(posedge clk); #1; chk0("w0.rd2_acc", 0, 0, 32'h00000001);
    rd0 = 1'b0;
    @(posedge clk); #1; chk0("w0.rd2_rdy", 0, 1, 32'h00000002);
    @(posedge clk); #1; chk0("w0.rd2_idle", 1, 0, 32'h00000002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
